uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- UART receiver in the UART (RX) clock domain.
- Oversamples the serial line and deframes start / data / optional parity / stop bits.
- Presents each accepted byte as a held parallel word plus a level valid flag. These form the source side (unsync bus + bus enable) of the downstream data synchronizer into the system clock domain.
- Error flags are consumed locally, in the same domain.

Parameters:
- DATA_WIDTH, 8: data bits per frame, and width of p_data.
- PRESCALE_WIDTH, 6: width of the prescale input.

Ports:
- CLK  in  1  RX oversampling clock.
- RST  in  1  async reset, active-low.
- rx_in  in  1  serial line; idle high.
- prescale  in  PRESCALE_WIDTH  oversampling ratio. Legal values are 8, 16 and 32; any other value behaves as 8.
- par_en  in  1  1 = parity bit present.
- par_typ  in  1  0 = even, 1 = odd.
- p_data  out  DATA_WIDTH  last accepted word, LSB received first.
- data_valid  out  1  level; p_data holds an accepted word.
- parity_error  out  1  one-cycle pulse.
- stop_error  out  1  one-cycle pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST=0): state=IDLE, counters=0, p_data=0, data_valid=0, parity_error=0, stop_error=0, busy=0. Reset mid-frame aborts the frame; no output changes except clearing to reset values.
- Configuration (prescale, par_en, par_typ) is sampled in IDLE only. It is held internally for the whole frame.
- edge_cnt counts 0..P-1 within each bit period (P = effective prescale). bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sample point = edge_cnt == P/2 - 1. The sampled bit is registered on that edge.
- FSM:
  - IDLE: rx_in=0 -> START, edge_cnt=0.
  - START: at the sample point, if sampled=1 (glitch) -> IDLE with no outputs changed. At edge_cnt=P-1 -> DATA. Only a validated start deasserts data_valid, on the START->DATA transition.
  - DATA: shift the sampled bit into the internal shift register (LSB first) at each sample point. At edge_cnt=P-1: if bit_cnt=DATA_WIDTH-1 go to PARITY when par_en, else to STOP.
  - PARITY: compare the sampled bit with the computed value (XOR of data bits, XORed with par_typ). Mismatch records the error. At edge_cnt=P-1 -> STOP.
  - STOP: at the sample point go to IDLE immediately; the remaining half bit is not waited out, so back-to-back frames are supported.
    - Stop=1 and no parity error: p_data <= shift register and data_valid <= 1, both registered, visible 1 CLK after the stop sample.
    - Stop=0: stop_error pulses and the frame is discarded.
    - Parity error with stop=1: parity_error pulses and the frame is discarded.
    - Both errors in one frame: both pulses fire in the same cycle.
- CDC contract:
  - p_data changes only on frame acceptance.
  - data_valid=0 for at least (P/2 + P) CLK before p_data changes again.
  - data_valid=1 for at least (P/2 + P) CLK after assertion.
  - The downstream synchronizer therefore sees stable data around each enable edge for P >= 8 with fast/slow ratio <= 1.
- A discarded frame leaves data_valid low, since it was already cleared on the START->DATA transition of that frame, and leaves p_data unchanged.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of samples at edge_cnt P/2-2, P/2-1 and P/2. The decision is registered at P/2; all state decisions that use a sample move from P/2-1 to P/2, and this applies to the START glitch check as well.
- Undefined: a single sample at P/2-1.
- The data_valid/p_data timing relative to the decision point is unchanged.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity type constants (PAR_EVEN=0, PAR_ODD=1);
  - legal prescale constants (8, 16, 32).
- One natural sub-module: uart_rx_sampler, containing the edge counter and sample/majority logic. It outputs sample_strobe, bit_end and sampled_bit.

Test Plan:
- prescale=8, par_en=0, frame 0xA5 then 8 idle bits -> p_data=0xA5, data_valid=1 one CLK after the stop sample, no error pulses.
- prescale=16, par_en=1, par_typ=0, 0x3C with parity bit 1 -> parity_error pulses once, data_valid stays 0, p_data retains its previous value.
- prescale=32, stop bit driven 0 -> stop_error pulse; with par_en=1 and bad parity in the same frame, both pulses fire in one cycle.
- 3-CLK low glitch on idle line with prescale=8 -> returns to IDLE, busy pulses ~4 CLK, data_valid/p_data unchanged.
- Back-to-back frames 0x01 and 0xFE, no idle gap -> data_valid drops at the second START->DATA, p_data becomes 0xFE one CLK after the second stop sample.
- RST low mid-DATA of frame 0x55 -> all outputs 0; the following clean frame 0x66 is received correctly. With UART_RX_MAJORITY_EN, a single-sample spike inside a data bit is rejected.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity type constants and the legal oversampling ratios.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: edge counter plus the bit
// sampling point. Optional macro UART_RX_MAJORITY_EN replaces the single
// centre sample with a 2-of-3 majority vote taken around the centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      rx_in,
  input  logic                      run,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sample_strobe,
  output logic                      bit_end,
  output logic                      sampled_bit
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] sample_pt;
  logic [PRESCALE_WIDTH-1:0] last;

  assign half      = prescale >> 1;
  assign sample_pt = half - ONE;
  assign last      = prescale - ONE;
  assign bit_end   = run && (edge_cnt == last);

  // Edge counter: held at 0 while idle, wraps every bit period, and is
  // cleared whenever the FSM is about to return to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!RST) begin
      edge_cnt <= '0;
    end else if (!run || clear || bit_end) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + ONE;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  logic s_mid;

  // Capture the two samples preceding the decision point.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (run) begin
      if (edge_cnt == sample_pt - ONE) s_early <= rx_in;
      if (edge_cnt == sample_pt)       s_mid   <= rx_in;
    end
  end

  assign sample_strobe = run && (edge_cnt == half);
  assign sampled_bit   = (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
`else
  assign sample_strobe = run && (edge_cnt == sample_pt);
  assign sampled_bit   = rx_in;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start / data (LSB first) / optional parity / stop.
// Accepted bytes are presented as a held word plus a level valid flag that
// feeds a downstream CDC synchronizer. Optional macro UART_RX_MAJORITY_EN
// selects majority-vote bit sampling in uart_rx_sampler.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error,
  output logic                      busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  uart_state_t               state;
  uart_state_t               state_next;
  logic [PRESCALE_WIDTH-1:0] eff_prescale;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic                      cfg_par_en;
  logic                      cfg_par_typ;
  logic [BCW-1:0]            bit_cnt;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_err_q;
  logic                      sample_strobe;
  logic                      bit_end;
  logic                      sampled_bit;

  // Map the prescale input onto a legal ratio; anything unsupported runs at 8.
  always_comb begin
    eff_prescale = PRESCALE_WIDTH'(PRESCALE_8);
    if (prescale == PRESCALE_WIDTH'(PRESCALE_16)) eff_prescale = PRESCALE_WIDTH'(PRESCALE_16);
    if (prescale == PRESCALE_WIDTH'(PRESCALE_32)) eff_prescale = PRESCALE_WIDTH'(PRESCALE_32);
  end

  // Configuration tracks the inputs in IDLE and is frozen for the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cfg_prescale <= PRESCALE_WIDTH'(PRESCALE_8);
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= PAR_EVEN;
    end else if (state == IDLE) begin
      cfg_prescale <= eff_prescale;
      cfg_par_en   <= par_en;
      cfg_par_typ  <= par_typ;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_in        (rx_in),
    .run          (state != IDLE),
    .clear        (state_next == IDLE),
    .prescale     (cfg_prescale),
    .sample_strobe(sample_strobe),
    .bit_end      (bit_end),
    .sampled_bit  (sampled_bit)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps paths that do
    // not assign it from inferring a latch.
    state_next = state;
    unique case (state)
      IDLE:   if (!rx_in) state_next = START;
      START: begin
        if (sample_strobe && sampled_bit) state_next = IDLE;
        else if (bit_end)                 state_next = DATA;
      end
      DATA:   if (bit_end && bit_cnt == BIT_LAST) state_next = cfg_par_en ? PARITY : STOP;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (sample_strobe) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: shift register, parity tracking, output word and flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      par_err_q    <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      unique case (state)
        IDLE: begin
          bit_cnt   <= '0;
          par_err_q <= 1'b0;
        end
        START: begin
          // Reaching the end of the start bit means it was not a glitch.
          if (bit_end) data_valid <= 1'b0;
        end
        DATA: begin
          if (sample_strobe) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
          if (bit_end)       bit_cnt <= bit_cnt + BIT_ONE;
        end
        PARITY: begin
          if (sample_strobe)
            par_err_q <= sampled_bit != ((^shreg) ^ (cfg_par_typ == PAR_ODD));
        end
        STOP: begin
          if (sample_strobe) begin
            stop_error   <= !sampled_bit;
            parity_error <= par_err_q;
            if (sampled_bit && !par_err_q) begin
              p_data     <= shreg;
              data_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame (default DATA_WIDTH / PRESCALE_WIDTH).
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = 1;
`else
  localparam int DEC = 0;
`endif

  logic          CLK;
  logic          RST;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic          dv_pre_sd, dv_post_sd;
    logic          dv_pre_acc, dv_acc;
    logic          pe_pre, pe_acc, pe_next;
    logic          se_pre, se_acc, se_next;
    logic [DW-1:0] pd_pre, pd_acc;
  } obs_t;

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .stop_error  (stop_error),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one frame; line values change on negedges. Offset o means "just after
  // posedge o", posedge 0 being the one where IDLE first sees the start bit.
  task automatic send_frame(input logic [DW-1:0] data, input int p, input logic pen,
                            input logic ptyp, input logic par_flip, input logic stop_bit,
                            input int spike, output obs_t ob);
    logic [11:0] bits;
    int s, o_acc;
    s = pen ? 10 : 9;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = data[i];
    if (pen) bits[9] = (^data) ^ ptyp ^ par_flip;
    bits[s] = stop_bit;
    prescale = PW'(p);
    par_en   = pen;
    par_typ  = ptyp;
    o_acc = s * p + p / 2 + DEC;
    for (int o = 0; o < (s + 1) * p; o++) begin
      rx_in = bits[o / p] ^ (o == spike);
      @(negedge CLK);
      if (o == p - 1) ob.dv_pre_sd  = data_valid;
      if (o == p)     ob.dv_post_sd = data_valid;
      if (o == o_acc - 1) begin
        ob.dv_pre_acc = data_valid; ob.pe_pre = parity_error;
        ob.se_pre = stop_error;     ob.pd_pre = p_data;
      end
      if (o == o_acc) begin
        ob.dv_acc = data_valid; ob.pe_acc = parity_error;
        ob.se_acc = stop_error; ob.pd_acc = p_data;
      end
      if (o == o_acc + 1) begin
        ob.pe_next = parity_error; ob.se_next = stop_error;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    rx_in = 1'b1; prescale = PW'(8); par_en = 1'b0; par_typ = PAR_EVEN;
    RST = 1'b1;
    #1 RST = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++; if (p_data !== 8'h00) begin miscompares++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    vectors++; if (parity_error !== 1'b0) begin miscompares++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
    vectors++; if (stop_error !== 1'b0) begin miscompares++; $display("FAIL reset_stop_error: got %b expected 0", stop_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    RST = 1'b1;
    idle(4);
  endtask

  task automatic test_basic;
    obs_t ob;
    send_frame(8'hA5, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, ob);
    vectors++; if (ob.dv_pre_acc !== 1'b0) begin miscompares++; $display("FAIL basic_dv_before: got %b expected 0", ob.dv_pre_acc); end
    vectors++; if (ob.dv_acc !== 1'b1) begin miscompares++; $display("FAIL basic_dv_after: got %b expected 1", ob.dv_acc); end
    vectors++; if (ob.pd_acc !== 8'hA5) begin miscompares++; $display("FAIL basic_p_data: got %h expected a5", ob.pd_acc); end
    vectors++; if (ob.pe_acc !== 1'b0) begin miscompares++; $display("FAIL basic_parity_error: got %b expected 0", ob.pe_acc); end
    vectors++; if (ob.se_acc !== 1'b0) begin miscompares++; $display("FAIL basic_stop_error: got %b expected 0", ob.se_acc); end
    idle(64);
    vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL basic_dv_hold: got %b expected 1", data_valid); end
    vectors++; if (p_data !== 8'hA5) begin miscompares++; $display("FAIL basic_p_data_hold: got %h expected a5", p_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_glitch;
    int busy_cnt = 0;
    prescale = PW'(8); par_en = 1'b0;
    rx_in = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge CLK);
      if (busy) busy_cnt++;
      if (n == 3) rx_in = 1'b1;
    end
    vectors++; if (busy_cnt !== 4 + DEC) begin miscompares++; $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt, 4 + DEC); end
    vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_dv: got %b expected 1", data_valid); end
    vectors++; if (p_data !== 8'hA5) begin miscompares++; $display("FAIL glitch_p_data: got %h expected a5", p_data); end
  endtask

  task automatic test_parity_ok;
    obs_t ob;
    send_frame(8'h3C, 16, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, ob);
    vectors++; if (ob.dv_post_sd !== 1'b0) begin miscompares++; $display("FAIL parok_dv_cleared: got %b expected 0", ob.dv_post_sd); end
    vectors++; if (ob.dv_acc !== 1'b1) begin miscompares++; $display("FAIL parok_dv: got %b expected 1", ob.dv_acc); end
    vectors++; if (ob.pd_acc !== 8'h3C) begin miscompares++; $display("FAIL parok_p_data: got %h expected 3c", ob.pd_acc); end
    vectors++; if (ob.pe_acc !== 1'b0) begin miscompares++; $display("FAIL parok_parity_error: got %b expected 0", ob.pe_acc); end
    idle(16);
  endtask

  task automatic test_parity_err;
    obs_t ob;
    send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, ob);
    vectors++; if (ob.dv_pre_sd !== 1'b1) begin miscompares++; $display("FAIL parerr_dv_pre_start: got %b expected 1", ob.dv_pre_sd); end
    vectors++; if (ob.dv_post_sd !== 1'b0) begin miscompares++; $display("FAIL parerr_dv_post_start: got %b expected 0", ob.dv_post_sd); end
    vectors++; if (ob.pe_pre !== 1'b0) begin miscompares++; $display("FAIL parerr_pe_early: got %b expected 0", ob.pe_pre); end
    vectors++; if (ob.pe_acc !== 1'b1) begin miscompares++; $display("FAIL parerr_pe_pulse: got %b expected 1", ob.pe_acc); end
    vectors++; if (ob.pe_next !== 1'b0) begin miscompares++; $display("FAIL parerr_pe_width: got %b expected 0", ob.pe_next); end
    vectors++; if (ob.se_acc !== 1'b0) begin miscompares++; $display("FAIL parerr_stop_error: got %b expected 0", ob.se_acc); end
    vectors++; if (ob.dv_acc !== 1'b0) begin miscompares++; $display("FAIL parerr_dv: got %b expected 0", ob.dv_acc); end
    vectors++; if (ob.pd_acc !== 8'h3C) begin miscompares++; $display("FAIL parerr_p_data: got %h expected 3c", ob.pd_acc); end
    idle(16);
  endtask

  task automatic test_stop_err;
    obs_t ob;
    send_frame(8'h5A, 32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, ob);
    vectors++; if (ob.se_pre !== 1'b0) begin miscompares++; $display("FAIL stoperr_se_early: got %b expected 0", ob.se_pre); end
    vectors++; if (ob.se_acc !== 1'b1) begin miscompares++; $display("FAIL stoperr_se_pulse: got %b expected 1", ob.se_acc); end
    vectors++; if (ob.se_next !== 1'b0) begin miscompares++; $display("FAIL stoperr_se_width: got %b expected 0", ob.se_next); end
    vectors++; if (ob.pe_acc !== 1'b0) begin miscompares++; $display("FAIL stoperr_parity_error: got %b expected 0", ob.pe_acc); end
    vectors++; if (ob.dv_acc !== 1'b0 || ob.pd_acc !== 8'h3C) begin miscompares++; $display("FAIL stoperr_discard: got dv=%b p_data=%h expected dv=0 p_data=3c", ob.dv_acc, ob.pd_acc); end
    idle(96);
    send_frame(8'h5A, 32, 1'b1, PAR_EVEN, 1'b1, 1'b0, -1, ob);
    vectors++; if (ob.pe_acc !== 1'b1) begin miscompares++; $display("FAIL both_pe: got %b expected 1", ob.pe_acc); end
    vectors++; if (ob.se_acc !== 1'b1) begin miscompares++; $display("FAIL both_se: got %b expected 1", ob.se_acc); end
    vectors++; if (ob.pe_pre !== 1'b0 || ob.se_pre !== 1'b0) begin miscompares++; $display("FAIL both_early: got pe=%b se=%b expected 0 0", ob.pe_pre, ob.se_pre); end
    vectors++; if (ob.dv_acc !== 1'b0 || ob.pd_acc !== 8'h3C) begin miscompares++; $display("FAIL both_discard: got dv=%b p_data=%h expected dv=0 p_data=3c", ob.dv_acc, ob.pd_acc); end
    idle(96);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL both_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    obs_t ob1, ob2;
    send_frame(8'h01, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, ob1);
    send_frame(8'hFE, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, ob2);
    vectors++; if (ob1.dv_acc !== 1'b1 || ob1.pd_acc !== 8'h01) begin miscompares++; $display("FAIL b2b_first: got dv=%b p_data=%h expected dv=1 p_data=01", ob1.dv_acc, ob1.pd_acc); end
    vectors++; if (ob2.dv_pre_sd !== 1'b1) begin miscompares++; $display("FAIL b2b_dv_held: got %b expected 1", ob2.dv_pre_sd); end
    vectors++; if (ob2.dv_post_sd !== 1'b0) begin miscompares++; $display("FAIL b2b_dv_drop: got %b expected 0", ob2.dv_post_sd); end
    vectors++; if (ob2.pd_pre !== 8'h01) begin miscompares++; $display("FAIL b2b_p_data_before: got %h expected 01", ob2.pd_pre); end
    vectors++; if (ob2.dv_pre_acc !== 1'b0) begin miscompares++; $display("FAIL b2b_dv_before: got %b expected 0", ob2.dv_pre_acc); end
    vectors++; if (ob2.dv_acc !== 1'b1) begin miscompares++; $display("FAIL b2b_dv_after: got %b expected 1", ob2.dv_acc); end
    vectors++; if (ob2.pd_acc !== 8'hFE) begin miscompares++; $display("FAIL b2b_p_data_after: got %h expected fe", ob2.pd_acc); end
    idle(16);
  endtask

  task automatic test_reset_mid;
    obs_t ob;
    logic [DW-1:0] d;
    d = 8'h55;
    prescale = PW'(8); par_en = 1'b0;
    rx_in = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      repeat (8) @(negedge CLK);
    end
    rx_in = d[3];
    repeat (3) @(negedge CLK);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    #2 RST = 1'b0;
    #1;
    vectors++; if (p_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_p_data: got %h expected 00", p_data); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_dv: got %b expected 0", data_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    vectors++; if (parity_error !== 1'b0 || stop_error !== 1'b0) begin miscompares++; $display("FAIL rstmid_errors: got pe=%b se=%b expected 0 0", parity_error, stop_error); end
    rx_in = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle(16);
    send_frame(8'h66, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, ob);
    vectors++; if (ob.dv_acc !== 1'b1) begin miscompares++; $display("FAIL rstmid_next_dv: got %b expected 1", ob.dv_acc); end
    vectors++; if (ob.pd_acc !== 8'h66) begin miscompares++; $display("FAIL rstmid_next_p_data: got %h expected 66", ob.pd_acc); end
    vectors++; if (ob.pe_acc !== 1'b0 || ob.se_acc !== 1'b0) begin miscompares++; $display("FAIL rstmid_next_errors: got pe=%b se=%b expected 0 0", ob.pe_acc, ob.se_acc); end
    idle(16);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_spike;
    obs_t ob;
    // One-cycle high spike on the centre sample of data bit 2 (0-based).
    send_frame(8'h00, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3 * 16 + 8, ob);
    vectors++; if (ob.dv_acc !== 1'b1) begin miscompares++; $display("FAIL spike_dv: got %b expected 1", ob.dv_acc); end
    vectors++; if (ob.pd_acc !== 8'h00) begin miscompares++; $display("FAIL spike_p_data: got %h expected 00", ob.pd_acc); end
    idle(16);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity_ok();
    test_parity_err();
    test_stop_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
    test_spike();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
